pixel_tap_sampler: RTL and testbench
====================================

# pixel_tap_sampler

Upstream feeder for the frequency analyzers. It counts the pixels of each image line, picks three tap pixels by index and converts each tap into a one-bit sample using a hysteresis comparator. Its outputs are the per-tap sample bits plus per-line status. Each bit drives the `sample_data` input of one frequency analyzer, all in the analyzer clock domain.

## Interface
Parameters:
- `LINE_LENGTH`, 1024: pixels per line; counter width is `$clog2(LINE_LENGTH)`.
- `PIXEL0_INDEX`, 15: tap 0 pixel index.
- `PIXEL1_INDEX`, 511: tap 1 pixel index.
- `PIXEL2_INDEX`, 1023: tap 2 pixel index.
- `THRESHOLD_HIGH`, 160: rise level; sample goes 0→1 when `data >= THRESHOLD_HIGH`.
- `THRESHOLD_LOW`, 96: fall level; sample goes 1→0 when `data <= THRESHOLD_LOW`. Must satisfy `THRESHOLD_LOW < THRESHOLD_HIGH`.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data`  in  8  pixel value.
- `data_valid`  in  1  `data` is valid this cycle.
- `line_start`  in  1  qualifies the current valid pixel as pixel 0 of a line.
- `enable`  in  1  level; sampling is permitted.
- `clear`  in  1  synchronous, active-high clear of results and status.
- `sample_data`  out  3  bit i is the hysteresis sample of tap i.
- `line_done`  out  1  one-cycle pulse when a complete line has been counted.
- `line_count`  out  32  number of complete lines; saturates at 0xFFFFFFFF.
- `line_error`  out  1  sticky; set when a line restarts early.

## Operation
- States: IDLE, WAIT_LINE, ACTIVE. Encoding is 2 bits.
- IDLE:
  - Entered on reset, or whenever `enable` = 0 (from any state, next cycle).
  - Sets `pixel_counter` to 0.
  - Holds `sample_data`.
- IDLE → WAIT_LINE: when `enable` = 1.
- WAIT_LINE:
  - Valid pixels without `line_start` are ignored.
  - On `data_valid & line_start`, the pixel is accepted as index 0 and the state moves to ACTIVE with `pixel_counter` = 1.
- ACTIVE:
  - Each pixel with `data_valid` = 1 and `line_start` = 0 is accepted at index `pixel_counter`; the counter then increments.
  - After index `LINE_LENGTH-1` is accepted, the block pulses `line_done`, increments `line_count` (saturating) and returns to WAIT_LINE.
- Early restart:
  - Trigger: `data_valid & line_start` in ACTIVE.
  - Sets `line_error`.
  - The pixel is taken as index 0 and the counter becomes 1.
  - The aborted line is not counted.
  - Taps not reached in the aborted line keep their previous sample value.
- Tap evaluation: when an accepted pixel's index equals `PIXELi_INDEX`:
  - `sample_data[i]` goes 0→1 if `data >= THRESHOLD_HIGH`.
  - `sample_data[i]` goes 1→0 if `data <= THRESHOLD_LOW`.
  - Otherwise it holds.
  - Equal indices are legal; every matching tap updates.
- `clear`:
  - Zeroes `sample_data`, `line_count`, `line_error` and `pixel_counter`.
  - Next state is WAIT_LINE if `enable` = 1, else IDLE.
  - No pixel is accepted in the clear cycle.
- Priority: `reset` > `clear` > `enable` = 0 > pixel acceptance.
- Comparisons are unsigned 8-bit; the counter never wraps beyond `LINE_LENGTH-1`.

## Timing
- Reset values: `sample_data` = 0, `line_done` = 0, `line_count` = 0, `line_error` = 0, state IDLE.
- `sample_data[i]` changes the cycle after its tap pixel is accepted (1-cycle latency).
- `line_done` and the new `line_count` value appear together, the cycle after the last pixel is accepted.
- `line_done` is high for exactly 1 cycle.
- There is no backpressure; one pixel can be accepted per cycle, including back-to-back lines. A `line_start` in the cycle right after the last pixel is accepted normally.
- Deasserting `enable` mid-line:
  - The next cycle is IDLE.
  - The partial line is discarded without setting `line_error`.
  - Re-enable resumes only at the next `line_start`.
- Reset or clear mid-line: the line is discarded and the block waits for a new `line_start`.

## Structure
- Shared package `pixel_tap_pkg`:
  - State encodings: IDLE = 0, WAIT_LINE = 1, ACTIVE = 2.
  - Default tap indices and thresholds, so that the analyzer manager and this block agree.
- Sub-module `tap_hysteresis_comparator`, instantiated 3 times.
  - Parameters: index and thresholds.
  - Inputs: accept strobe, pixel index, data, clear.
  - Output: registered sample bit.
- Elaboration-time checks: every tap index is below `LINE_LENGTH`, and `THRESHOLD_LOW < THRESHOLD_HIGH`.

## Test plan
- Full line, defaults: all pixels 200 with `line_start` on pixel 0 → `sample_data` = 3'b111. The bits rise 1 cycle after pixels 15, 511 and 1023 respectively; `line_done` pulses once; `line_count` = 1.
- Hysteresis: next line taps = 120 → `sample_data` stays 3'b111. Following line taps = 90 → `sample_data` = 3'b000. `line_count` = 3.
- Early restart: `line_start` at pixel 300 → `line_error` = 1, `line_count` unchanged. Tap 0 reflects the aborted line; taps 1 and 2 hold. A subsequent full line counts normally.
- Enable drop at pixel 600, re-enable mid-stream → pixels ignored until the next `line_start`. `line_error` = 0 and no `line_done` for the partial line.
- Simultaneous clear and last pixel → no `line_done`; `line_count` = 0, `sample_data` = 0, state WAIT_LINE.
- Reset asserted in ACTIVE with `clear` = 1 and `enable` = 1 → next cycle all outputs 0, state IDLE.
- Saturation: `line_count` forced near the top by running `LINE_LENGTH` = 4 with 2^32+1 lines (or backdoor preload) → `line_count` holds 0xFFFFFFFF while `line_done` still pulses.

Source files
------------

// File: rtl/pixel_tap_pkg.sv
// Definitions shared by the pixel tap sampler and the analyzer manager:
// FSM encoding, default tap indices and hysteresis thresholds.
package pixel_tap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_t;

  localparam int unsigned DEF_LINE_LENGTH    = 1024;
  localparam int unsigned DEF_PIXEL0_INDEX   = 15;
  localparam int unsigned DEF_PIXEL1_INDEX   = 511;
  localparam int unsigned DEF_PIXEL2_INDEX   = 1023;
  localparam int unsigned DEF_THRESHOLD_HIGH = 160;
  localparam int unsigned DEF_THRESHOLD_LOW  = 96;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/tap_hysteresis_comparator.sv
// One tap: when the accepted pixel index matches TAP_INDEX, the sample bit
// follows the pixel through a two-level hysteresis comparator.
module tap_hysteresis_comparator
  import pixel_tap_pkg::*;
#(
  parameter int unsigned IDX_W          = 10,
  parameter int unsigned TAP_INDEX      = DEF_PIXEL0_INDEX,
  parameter int unsigned THRESHOLD_HIGH = DEF_THRESHOLD_HIGH,
  parameter int unsigned THRESHOLD_LOW  = DEF_THRESHOLD_LOW
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_accept,
  input  logic [IDX_W-1:0] i_index,
  input  logic [7:0]       i_data,
  input  logic             i_clear,
  output logic             o_sample
);

  localparam logic [IDX_W-1:0] TAP_IDX = IDX_W'(TAP_INDEX);
  localparam logic [7:0]       TH_HIGH = 8'(THRESHOLD_HIGH);
  localparam logic [7:0]       TH_LOW  = 8'(THRESHOLD_LOW);

  logic r_sample;
  logic w_hit;

  assign w_hit = i_accept && (i_index == TAP_IDX);

  // Between the two levels the previous sample is held.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_sample <= 1'b0;
    end else if (w_hit) begin
      if (i_data >= TH_HIGH) begin
        r_sample <= 1'b1;
      end else if (i_data <= TH_LOW) begin
        r_sample <= 1'b0;
      end
    end
  end

  assign o_sample = r_sample;

endmodule

// File: rtl/pixel_tap_sampler.sv
// Counts pixels per line, samples three tap pixels through hysteresis
// comparators and reports per-line status.
//
//   state        | meaning
//   ST_IDLE      | sampling disabled, pixel counter held at 0
//   ST_WAIT_LINE | enabled, waiting for a valid pixel with line_start
//   ST_ACTIVE    | inside a line, accepting every valid pixel
module pixel_tap_sampler
  import pixel_tap_pkg::*;
#(
  parameter int unsigned LINE_LENGTH    = DEF_LINE_LENGTH,
  parameter int unsigned PIXEL0_INDEX   = DEF_PIXEL0_INDEX,
  parameter int unsigned PIXEL1_INDEX   = DEF_PIXEL1_INDEX,
  parameter int unsigned PIXEL2_INDEX   = DEF_PIXEL2_INDEX,
  parameter int unsigned THRESHOLD_HIGH = DEF_THRESHOLD_HIGH,
  parameter int unsigned THRESHOLD_LOW  = DEF_THRESHOLD_LOW
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        data_valid,
  input  logic        line_start,
  input  logic        enable,
  input  logic        clear,
  output logic [2:0]  sample_data,
  output logic        line_done,
  output logic [31:0] line_count,
  output logic        line_error
);

  localparam int unsigned    CNT_W    = $clog2(LINE_LENGTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_LENGTH - 1);

  if (LINE_LENGTH < 2) begin : g_bad_length
    $error("pixel_tap_sampler: LINE_LENGTH must be at least 2");
  end
  if (PIXEL0_INDEX >= LINE_LENGTH || PIXEL1_INDEX >= LINE_LENGTH ||
      PIXEL2_INDEX >= LINE_LENGTH) begin : g_bad_index
    $error("pixel_tap_sampler: tap index outside the line");
  end
  if (THRESHOLD_LOW >= THRESHOLD_HIGH) begin : g_bad_threshold
    $error("pixel_tap_sampler: THRESHOLD_LOW must be below THRESHOLD_HIGH");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_pixel_counter;
  logic [CNT_W-1:0]   w_index;
  logic               w_accept;
  logic               w_restart;
  logic               w_last;
  logic               r_line_done;
  logic [31:0]        r_line_count;
  logic               r_line_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = enable ? ST_WAIT_LINE : ST_IDLE;
    end else if (!enable) begin
      w_state_next = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      w_state_next = ST_WAIT_LINE;
    end else if (w_accept) begin
      w_state_next = w_last ? ST_WAIT_LINE : ST_ACTIVE;
    end
  end

  // A line_start inside ACTIVE aborts the line and reuses the pixel as index 0.
  always_comb begin
    w_accept  = 1'b0;
    w_restart = 1'b0;
    w_index   = r_pixel_counter;
    if (!clear && enable && data_valid) begin
      case (r_state)
        ST_WAIT_LINE: begin
          if (line_start) begin
            w_accept = 1'b1;
            w_index  = '0;
          end
        end
        ST_ACTIVE: begin
          w_accept = 1'b1;
          if (line_start) begin
            w_restart = 1'b1;
            w_index   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_last = (w_index == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_pixel_counter <= '0;
      r_line_done     <= 1'b0;
      r_line_count    <= '0;
      r_line_error    <= 1'b0;
    end else begin
      r_line_done <= w_accept && w_last;
      if (w_accept && w_last) begin
        r_line_count <= sat_inc32(r_line_count);
      end
      if (w_restart) begin
        r_line_error <= 1'b1;
      end
      if (!enable || r_state == ST_IDLE) begin
        r_pixel_counter <= '0;
      end else if (w_accept) begin
        r_pixel_counter <= w_last ? '0 : w_index + CNT_W'(1);
      end
    end
  end

  tap_hysteresis_comparator #(
    .IDX_W(CNT_W), .TAP_INDEX(PIXEL0_INDEX),
    .THRESHOLD_HIGH(THRESHOLD_HIGH), .THRESHOLD_LOW(THRESHOLD_LOW)
  ) u_tap0 (
    .i_clock(clock), .i_reset(reset), .i_accept(w_accept), .i_index(w_index),
    .i_data(data), .i_clear(clear), .o_sample(sample_data[0])
  );

  tap_hysteresis_comparator #(
    .IDX_W(CNT_W), .TAP_INDEX(PIXEL1_INDEX),
    .THRESHOLD_HIGH(THRESHOLD_HIGH), .THRESHOLD_LOW(THRESHOLD_LOW)
  ) u_tap1 (
    .i_clock(clock), .i_reset(reset), .i_accept(w_accept), .i_index(w_index),
    .i_data(data), .i_clear(clear), .o_sample(sample_data[1])
  );

  tap_hysteresis_comparator #(
    .IDX_W(CNT_W), .TAP_INDEX(PIXEL2_INDEX),
    .THRESHOLD_HIGH(THRESHOLD_HIGH), .THRESHOLD_LOW(THRESHOLD_LOW)
  ) u_tap2 (
    .i_clock(clock), .i_reset(reset), .i_accept(w_accept), .i_index(w_index),
    .i_data(data), .i_clear(clear), .o_sample(sample_data[2])
  );

  assign line_done  = r_line_done;
  assign line_count = r_line_count;
  assign line_error = r_line_error;

endmodule

// File: tb/tb_pixel_tap_sampler.sv
// Bench for pixel_tap_sampler: default-size instance for the line-level
// scenarios, 4-pixel instance for vector table, saturation and random runs.
module tb_pixel_tap_sampler;
  import pixel_tap_pkg::*;

  localparam int S_LL = 4;
  localparam int S_P0 = 0;
  localparam int S_P1 = 2;
  localparam int S_P2 = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        d_reset, d_data_valid, d_line_start, d_enable, d_clear;
  logic [7:0]  d_data;
  logic [2:0]  d_sample;
  logic        d_done, d_err;
  logic [31:0] d_count;

  logic        s_reset, s_data_valid, s_line_start, s_enable, s_clear;
  logic [7:0]  s_data;
  logic [2:0]  s_sample;
  logic        s_done, s_err;
  logic [31:0] s_count;

  pixel_tap_sampler dut (
    .clock(clock), .reset(d_reset), .data(d_data), .data_valid(d_data_valid),
    .line_start(d_line_start), .enable(d_enable), .clear(d_clear),
    .sample_data(d_sample), .line_done(d_done), .line_count(d_count),
    .line_error(d_err)
  );

  pixel_tap_sampler #(
    .LINE_LENGTH(S_LL), .PIXEL0_INDEX(S_P0), .PIXEL1_INDEX(S_P1), .PIXEL2_INDEX(S_P2)
  ) dut_s (
    .clock(clock), .reset(s_reset), .data(s_data), .data_valid(s_data_valid),
    .line_start(s_line_start), .enable(s_enable), .clear(s_clear),
    .sample_data(s_sample), .line_done(s_done), .line_count(s_count),
    .line_error(s_err)
  );

  int total = 0;
  int bad   = 0;
  int d_done_n = 0;

  always @(posedge clock) if (d_done === 1'b1) d_done_n++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic d_cycle(input logic rst, clr, en, dv, ls, input logic [7:0] v);
    @(negedge clock);
    d_reset = rst; d_clear = clr; d_enable = en;
    d_data_valid = dv; d_line_start = ls; d_data = v;
    @(posedge clock); #1;
  endtask

  task automatic d_pixel(input logic ls, input logic [7:0] v);
    d_cycle(1'b0, 1'b0, 1'b1, 1'b1, ls, v);
  endtask

  task automatic d_full_line(input logic [7:0] v);
    for (int k = 0; k < 1024; k++) d_pixel(k == 0, v);
  endtask

  task automatic s_cycle(input logic rst, clr, en, dv, ls, input logic [7:0] v);
    @(negedge clock);
    s_reset = rst; s_clear = clr; s_enable = en;
    s_data_valid = dv; s_line_start = ls; s_data = v;
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic rst, clr, en, dv, ls;
    logic [7:0] d;
    logic [2:0] smp;
    logic done;
    logic [31:0] cnt;
    logic err;
  } vec_t;

  function automatic vec_t mk(logic rst, clr, en, dv, ls, logic [7:0] d,
                              logic [2:0] smp, logic done, logic [31:0] cnt, logic err);
    vec_t v;
    v.rst = rst; v.clr = clr; v.en = en; v.dv = dv; v.ls = ls; v.d = d;
    v.smp = smp; v.done = done; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  // Reference: what the block has seen so far, in line terms.
  typedef struct {
    bit on;
    int pos;
    logic [2:0] smp;
    logic [31:0] cnt;
    bit err;
    bit done;
  } model_t;

  function automatic model_t model_step(model_t m, bit rst, bit clr, bit en,
                                        bit dv, bit ls, logic [7:0] d);
    model_t n = m;
    int k = -1;
    int tap_at[3];
    tap_at = '{S_P0, S_P1, S_P2};
    n.done = 0;
    if (rst) begin
      n.on = 0; n.pos = -1; n.smp = '0; n.cnt = '0; n.err = 0;
      return n;
    end
    if (clr) begin
      n.on = en; n.pos = -1; n.smp = '0; n.cnt = '0; n.err = 0;
      return n;
    end
    if (!en) begin
      n.on = 0; n.pos = -1;
      return n;
    end
    if (!m.on) begin
      n.on = 1;
      return n;
    end
    if (dv) begin
      if (ls) begin
        if (m.pos >= 0) n.err = 1;
        k = 0;
      end else if (m.pos >= 0) begin
        k = m.pos;
      end
    end
    if (k >= 0) begin
      for (int i = 0; i < 3; i++) begin
        if (k == tap_at[i]) begin
          if (d >= 8'd160) n.smp[i] = 1'b1;
          else if (d <= 8'd96) n.smp[i] = 1'b0;
        end
      end
      if (k == S_LL - 1) begin
        n.done = 1;
        n.pos  = -1;
        if (m.cnt != 32'hFFFF_FFFF) n.cnt = m.cnt + 32'd1;
      end else begin
        n.pos = k + 1;
      end
    end
    return n;
  endfunction

  initial begin
    vec_t   vecs[$];
    model_t m;
    int     snap;

    d_reset = 1; d_clear = 0; d_enable = 0; d_data_valid = 0; d_line_start = 0; d_data = 0;
    s_reset = 1; s_clear = 0; s_enable = 0; s_data_valid = 0; s_line_start = 0; s_data = 0;

    // ---------------- default-size instance ----------------
    d_cycle(1, 0, 0, 0, 0, 8'd0);
    check("rst_sample", d_sample, 3'b000);
    check("rst_done", d_done, 1'b0);
    check("rst_count", d_count, 32'd0);
    check("rst_error", d_err, 1'b0);
    check("rst_state", dut.r_state, ST_IDLE);

    d_cycle(0, 0, 1, 0, 0, 8'd0);
    snap = d_done_n;
    for (int k = 0; k < 1024; k++) begin
      d_pixel(k == 0, 8'd200);
      if (k == 14 || k == 15 || k == 510 || k == 511 || k == 1022 || k == 1023)
        check($sformatf("full_rise_k%0d", k), d_sample, {k >= 1023, k >= 511, k >= 15});
      if (k == 1022) check("full_done_early", d_done, 1'b0);
    end
    check("full_done", d_done, 1'b1);
    check("full_count", d_count, 32'd1);
    d_cycle(0, 0, 1, 0, 0, 8'd0);
    check("full_done_pulse", d_done, 1'b0);
    check("full_done_once", d_done_n - snap, 1);

    d_full_line(8'd120);
    check("hyst_hold", d_sample, 3'b111);
    d_full_line(8'd90);
    check("hyst_fall", d_sample, 3'b000);
    check("hyst_count", d_count, 32'd3);
    check("hyst_done_b2b", d_done, 1'b1);

    for (int k = 0; k < 300; k++) d_pixel(k == 0, 8'd200);
    d_pixel(1'b1, 8'd200);
    check("restart_error", d_err, 1'b1);
    check("restart_count", d_count, 32'd3);
    check("restart_sample", d_sample, 3'b001);
    check("restart_done", d_done, 1'b0);
    for (int k = 1; k < 1024; k++) d_pixel(1'b0, 8'd200);
    check("after_restart_count", d_count, 32'd4);
    check("after_restart_sample", d_sample, 3'b111);
    check("after_restart_done", d_done, 1'b1);

    d_cycle(0, 1, 1, 0, 0, 8'd0);
    check("clear_count", d_count, 32'd0);
    check("clear_error", d_err, 1'b0);
    check("clear_sample", d_sample, 3'b000);
    snap = d_done_n;
    for (int k = 0; k < 600; k++) d_pixel(k == 0, 8'd200);
    d_cycle(0, 0, 0, 1, 0, 8'd200);
    for (int k = 601; k < 1024; k++) d_pixel(1'b0, 8'd200);
    d_cycle(0, 0, 1, 0, 0, 8'd0);
    check("endrop_sample", d_sample, 3'b011);
    check("endrop_error", d_err, 1'b0);
    check("endrop_count", d_count, 32'd0);
    check("endrop_no_done", d_done_n - snap, 0);

    for (int k = 0; k < 1023; k++) d_pixel(k == 0, 8'd200);
    check("pre_clear_sample", d_sample, 3'b011);
    d_cycle(0, 1, 1, 1, 0, 8'd200);
    check("clr_last_done", d_done, 1'b0);
    check("clr_last_count", d_count, 32'd0);
    check("clr_last_sample", d_sample, 3'b000);
    check("clr_last_state", dut.r_state, ST_WAIT_LINE);
    d_cycle(0, 0, 1, 0, 0, 8'd0);
    check("clr_last_no_done", d_done_n - snap, 0);

    d_full_line(8'd200);
    check("clr_then_line_count", d_count, 32'd1);
    for (int k = 0; k < 20; k++) d_pixel(k == 0, 8'd200);
    d_pixel(1'b1, 8'd200);
    check("pre_rst_error", d_err, 1'b1);
    d_pixel(1'b0, 8'd200);
    d_cycle(1, 1, 1, 1, 0, 8'd200);
    check("mid_rst_sample", d_sample, 3'b000);
    check("mid_rst_count", d_count, 32'd0);
    check("mid_rst_error", d_err, 1'b0);
    check("mid_rst_done", d_done, 1'b0);
    check("mid_rst_state", dut.r_state, ST_IDLE);
    d_cycle(0, 0, 0, 0, 0, 8'd0);

    // ---------------- small instance: vector table ----------------
    vecs.push_back(mk(1,0,0,0,0,8'd0,   3'b000,0,32'd0,0));
    vecs.push_back(mk(0,0,1,1,1,8'd200, 3'b000,0,32'd0,0));
    vecs.push_back(mk(0,0,1,1,1,8'd200, 3'b001,0,32'd0,0));
    vecs.push_back(mk(0,0,1,1,0,8'd50,  3'b001,0,32'd0,0));
    vecs.push_back(mk(0,0,1,1,0,8'd170, 3'b111,0,32'd0,0));
    vecs.push_back(mk(0,0,1,1,0,8'd10,  3'b111,1,32'd1,0));
    vecs.push_back(mk(0,0,1,1,1,8'd130, 3'b111,0,32'd1,0));
    vecs.push_back(mk(0,0,1,1,0,8'd0,   3'b111,0,32'd1,0));
    vecs.push_back(mk(0,0,1,1,1,8'd90,  3'b110,0,32'd1,1));
    vecs.push_back(mk(0,0,1,1,0,8'd200, 3'b110,0,32'd1,1));
    vecs.push_back(mk(0,0,1,0,0,8'd0,   3'b110,0,32'd1,1));
    vecs.push_back(mk(0,0,1,1,0,8'd96,  3'b000,0,32'd1,1));
    vecs.push_back(mk(0,0,1,1,0,8'd5,   3'b000,1,32'd2,1));
    vecs.push_back(mk(0,0,0,1,1,8'd200, 3'b000,0,32'd2,1));
    vecs.push_back(mk(0,0,1,1,1,8'd200, 3'b000,0,32'd2,1));
    vecs.push_back(mk(0,0,1,1,0,8'd200, 3'b000,0,32'd2,1));
    vecs.push_back(mk(0,1,1,1,1,8'd200, 3'b000,0,32'd0,0));
    vecs.push_back(mk(0,0,1,1,1,8'd160, 3'b001,0,32'd0,0));
    vecs.push_back(mk(0,0,1,1,0,8'd159, 3'b001,0,32'd0,0));
    vecs.push_back(mk(0,0,1,1,0,8'd160, 3'b111,0,32'd0,0));
    vecs.push_back(mk(0,1,1,1,0,8'd200, 3'b000,0,32'd0,0));
    vecs.push_back(mk(0,0,1,1,0,8'd200, 3'b000,0,32'd0,0));
    vecs.push_back(mk(1,1,1,1,0,8'd200, 3'b000,0,32'd0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      s_cycle(vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].dv, vecs[i].ls, vecs[i].d);
      check($sformatf("vec%0d_sample", i), s_sample, vecs[i].smp);
      check($sformatf("vec%0d_done", i), s_done, vecs[i].done);
      check($sformatf("vec%0d_count", i), s_count, vecs[i].cnt);
      check($sformatf("vec%0d_error", i), s_err, vecs[i].err);
    end

    // ---------------- saturation via preload ----------------
    s_cycle(0, 0, 1, 0, 0, 8'd0);
    dut_s.r_line_count = 32'hFFFF_FFFE;
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < S_LL; k++) begin
        s_cycle(0, 0, 1, 1, k == 0, 8'd200);
        if (k == 0 && l > 0) check($sformatf("sat_done_low%0d", l), s_done, 1'b0);
      end
      check($sformatf("sat_done%0d", l), s_done, 1'b1);
      check($sformatf("sat_count%0d", l), s_count, 32'hFFFF_FFFF);
    end

    // ---------------- random against the reference ----------------
    s_cycle(1, 0, 0, 0, 0, 8'd0);
    m = '{on: 0, pos: -1, smp: 3'b000, cnt: 32'd0, err: 0, done: 0};
    for (int c = 0; c < 3000; c++) begin
      bit rst, clr, en, dv, ls;
      logic [7:0] d;
      rst = ($urandom_range(199) == 0);
      clr = ($urandom_range(49) == 0);
      en  = ($urandom_range(19) != 0);
      dv  = ($urandom_range(4) != 0);
      ls  = ($urandom_range(5) == 0);
      d   = 8'($urandom_range(255));
      s_cycle(rst, clr, en, dv, ls, d);
      m = model_step(m, rst, clr, en, dv, ls, d);
      check($sformatf("rnd%0d_sample", c), s_sample, m.smp);
      check($sformatf("rnd%0d_done", c), s_done, m.done);
      check($sformatf("rnd%0d_count", c), s_count, m.cnt);
      check($sformatf("rnd%0d_error", c), s_err, m.err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
